// File: rtl/axi4_pkg.sv
// Shared AXI4 read-slave types: burst encodings, response codes, the queued AR request and the per-beat descriptor.
package axi4_pkg;

    // Request fields are sized to the default port widths; narrower ports are zero-extended into them.
    localparam int REQ_ID_W   = 8;
    localparam int REQ_ADDR_W = 32;

    typedef enum logic [1:0] {
        FIXED = 2'd0,
        INCR  = 2'd1,
        WRAP  = 2'd2
    } burst_e;

    localparam logic [1:0] RESP_OKAY   = 2'd0;
    localparam logic [1:0] RESP_SLVERR = 2'd2;
    localparam logic [1:0] RESP_DECERR = 2'd3;

    typedef struct packed {
        logic [REQ_ID_W-1:0]   id;
        logic [REQ_ADDR_W-1:0] addr;
        logic [7:0]            len;
        logic [2:0]            size;
        burst_e                burst;
    } ar_req_t;

    typedef struct packed {
        logic [REQ_ID_W-1:0] id;
        logic [1:0]          resp;
        logic                last;
    } beat_t;

    function automatic logic wrap_len_ok(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

endpackage

// File: rtl/axi4_burst_addr_gen.sv
// Combinational beat decoder: word index, response, last flag and next address for the current beat.
// WRAP bursts are honoured only when AXI4_RD_SLAVE_WRAP_EN is defined; otherwise they return SLVERR.
module axi4_burst_addr_gen
    import axi4_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 1024
) (
    input  ar_req_t                      req,
    input  logic [7:0]                   beat,
    output logic [ADDR_WIDTH-1:0]        next_addr,
    output logic [$clog2(MEM_DEPTH)-1:0] word,
    output beat_t                        info
);
    localparam int BYTES    = DATA_WIDTH / 8;
    localparam int BYTE_LSB = $clog2(BYTES);
    localparam int MEM_BA   = $clog2(MEM_DEPTH) + BYTE_LSB;

    logic [ADDR_WIDTH-1:0] addr;
    logic [ADDR_WIDTH-1:0] incr_addr;
    logic                  slverr;
    logic                  decerr;

    assign addr      = req.addr[ADDR_WIDTH-1:0];
    assign incr_addr = addr + ADDR_WIDTH'(BYTES);
    assign word      = addr[MEM_BA-1:BYTE_LSB];
    assign decerr    = (addr >> MEM_BA) != '0;

`ifdef AXI4_RD_SLAVE_WRAP_EN
    logic [ADDR_WIDTH-1:0] wrap_mask;
    assign wrap_mask = ((ADDR_WIDTH'(req.len) + ADDR_WIDTH'(1)) << BYTE_LSB) - ADDR_WIDTH'(1);
`endif

    always_comb begin
        slverr    = (req.size != 3'(BYTE_LSB));
        next_addr = incr_addr;
        case (req.burst)
            FIXED: next_addr = addr;
            INCR:  next_addr = incr_addr;
            WRAP: begin
`ifdef AXI4_RD_SLAVE_WRAP_EN
                // Stay inside the aligned window, replacing only the offset bits.
                next_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
                if (!wrap_len_ok(req.len)) slverr = 1'b1;
`else
                slverr = 1'b1;
`endif
            end
            default: slverr = 1'b1;
        endcase
    end

    always_comb begin
        info.id   = req.id;
        info.last = (beat == req.len);
        info.resp = slverr ? RESP_SLVERR : (decerr ? RESP_DECERR : RESP_OKAY);
    end

endmodule

// File: rtl/axi4_rd_slave_mem.sv
// AXI4 read-only slave over a word-addressed sync-read RAM with a queued AR channel and 2-entry R buffer.
// Optional WRAP support via AXI4_RD_SLAVE_WRAP_EN.  Engine states:  S_IDLE | no active burst
//                                                                  S_BURST | issuing/draining one burst
module axi4_rd_slave_mem
    import axi4_pkg::*;
#(
    parameter int ID_WIDTH      = 8,
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int MEM_DEPTH     = 1024,
    parameter int AR_FIFO_DEPTH = 4
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [ID_WIDTH-1:0]          ARID,
    input  logic [ADDR_WIDTH-1:0]        ARADDR,
    input  logic [7:0]                   ARLEN,
    input  logic [2:0]                   ARSIZE,
    input  logic [1:0]                   ARBURST,
    input  logic                         ARVALID,
    output logic                         ARREADY,
    output logic [ID_WIDTH-1:0]          RID,
    output logic [DATA_WIDTH-1:0]        RDATA,
    output logic [1:0]                   RRESP,
    output logic                         RLAST,
    output logic                         RVALID,
    input  logic                         RREADY,
    input  logic                         mem_we,
    input  logic [$clog2(MEM_DEPTH)-1:0] mem_waddr,
    input  logic [DATA_WIDTH-1:0]        mem_wdata
);
    localparam int              MEM_AW = $clog2(MEM_DEPTH);
    localparam int              Q_AW   = $clog2(AR_FIFO_DEPTH);
    localparam logic [Q_AW:0]   Q_FULL = (Q_AW+1)'(AR_FIFO_DEPTH);

    typedef enum logic {S_IDLE, S_BURST} state_e;

    ar_req_t               q_mem [AR_FIFO_DEPTH];
    logic [Q_AW-1:0]       q_wptr, q_rptr;
    logic [Q_AW:0]         q_cnt, q_cnt_next;
    logic                  arready_r;
    ar_req_t               ar_in, head;
    logic                  push, pop, q_empty;

    state_e                state;
    ar_req_t               act_req, cur_req;
    logic [7:0]            beat_cnt, cur_beat;
    logic                  issued_all, can_issue, issue;
    logic [ADDR_WIDTH-1:0] next_addr;
    logic [MEM_AW-1:0]     rd_word;
    beat_t                 cur_info;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
    logic [DATA_WIDTH-1:0] ram_q;
    logic                  ds_valid;
    beat_t                 ds_info;

    logic [DATA_WIDTH-1:0] ob_data [2];
    beat_t                 ob_info [2];
    logic                  ob_wptr, ob_rptr;
    logic [1:0]            ob_cnt;
    logic [2:0]            occ;
    logic                  r_pop, rlast_hs;

    always_comb begin
        ar_in       = '0;
        ar_in.id    = REQ_ID_W'(ARID);
        ar_in.addr  = REQ_ADDR_W'(ARADDR);
        ar_in.len   = ARLEN;
        ar_in.size  = ARSIZE;
        ar_in.burst = burst_e'(ARBURST);
    end

    assign push       = ARVALID && arready_r;
    assign q_empty    = (q_cnt == '0);
    assign head       = q_mem[q_rptr];
    assign r_pop      = RVALID && RREADY;
    assign rlast_hs   = r_pop && ob_info[ob_rptr].last;
    assign pop        = !q_empty && ((state == S_IDLE) || rlast_hs);
    assign q_cnt_next = q_cnt + (Q_AW+1)'(push) - (Q_AW+1)'(pop);

    always_ff @(posedge clock) begin
        if (push) q_mem[q_wptr] <= ar_in;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            q_wptr    <= '0;
            q_rptr    <= '0;
            q_cnt     <= '0;
            arready_r <= 1'b0;
        end else begin
            if (push) q_wptr <= q_wptr + Q_AW'(1);
            if (pop)  q_rptr <= q_rptr + Q_AW'(1);
            q_cnt     <= q_cnt_next;
            arready_r <= (q_cnt_next != Q_FULL);
        end
    end

    // A popped request issues its first beat in the same cycle, so the head bypasses the engine registers.
    assign cur_req   = pop ? head : act_req;
    assign cur_beat  = pop ? 8'd0 : beat_cnt;
    assign can_issue = pop || ((state == S_BURST) && !issued_all);
    assign occ       = {1'b0, ob_cnt} + {2'b0, ds_valid} - {2'b0, r_pop};
    assign issue     = can_issue && (occ < 3'd2);

    axi4_burst_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_DEPTH  (MEM_DEPTH)
    ) u_addr_gen (
        .req       (cur_req),
        .beat      (cur_beat),
        .next_addr (next_addr),
        .word      (rd_word),
        .info      (cur_info)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= S_IDLE;
            act_req    <= '0;
            beat_cnt   <= '0;
            issued_all <= 1'b0;
        end else begin
            case (state)
                S_IDLE:  if (pop) state <= S_BURST;
                S_BURST: if (rlast_hs && !pop) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
            if (pop) begin
                act_req    <= head;
                beat_cnt   <= '0;
                issued_all <= 1'b0;
            end
            if (issue) begin
                act_req.addr <= REQ_ADDR_W'(next_addr);
                beat_cnt     <= cur_beat + 8'd1;
                issued_all   <= cur_info.last;
            end
        end
    end

    // Read-first: a same-cycle preload write is not visible to the read.
    always_ff @(posedge clock) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
        if (issue && (cur_info.resp == RESP_OKAY)) ram_q <= mem[rd_word];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ds_valid <= 1'b0;
            ds_info  <= '0;
        end else begin
            ds_valid <= issue;
            if (issue) ds_info <= cur_info;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ob_wptr <= 1'b0;
            ob_rptr <= 1'b0;
            ob_cnt  <= '0;
            for (int i = 0; i < 2; i++) begin
                ob_data[i] <= '0;
                ob_info[i] <= '0;
            end
        end else begin
            if (ds_valid) begin
                ob_data[ob_wptr] <= (ds_info.resp == RESP_OKAY) ? ram_q : '0;
                ob_info[ob_wptr] <= ds_info;
                ob_wptr          <= ~ob_wptr;
            end
            if (r_pop) ob_rptr <= ~ob_rptr;
            ob_cnt <= ob_cnt + 2'(ds_valid) - 2'(r_pop);
        end
    end

    assign ARREADY = arready_r;
    assign RVALID  = (ob_cnt != 2'd0);
    assign RDATA   = ob_data[ob_rptr];
    assign RID     = ob_info[ob_rptr].id[ID_WIDTH-1:0];
    assign RRESP   = ob_info[ob_rptr].resp;
    assign RLAST   = ob_info[ob_rptr].last;

endmodule

// File: tb/tb_axi4_rd_slave_mem.sv
// Directed bench for axi4_rd_slave_mem: memory preloaded with mem[i]=i, beats scored against hand-built queues.
module tb_axi4_rd_slave_mem;

    logic        clock = 1'b0;
    logic        reset;
    logic [7:0]  ARID;
    logic [31:0] ARADDR;
    logic [7:0]  ARLEN;
    logic [2:0]  ARSIZE;
    logic [1:0]  ARBURST;
    logic        ARVALID;
    logic        ARREADY;
    logic [7:0]  RID;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RLAST;
    logic        RVALID;
    logic        RREADY;
    logic        mem_we;
    logic [9:0]  mem_waddr;
    logic [31:0] mem_wdata;

    axi4_rd_slave_mem #(
        .ID_WIDTH(8), .ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(1024), .AR_FIFO_DEPTH(4)
    ) dut (
        .clock(clock), .reset(reset),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    logic [7:0]  b_id[$];
    logic [31:0] b_data[$];
    logic [1:0]  b_resp[$];
    logic        b_last[$];
    int          b_cyc[$];
    int          ar_cyc[$];

    logic [7:0]  e_id[$];
    logic [31:0] e_data[$];
    logic [1:0]  e_resp[$];
    logic        e_last[$];

    always @(posedge clock) cyc++;

    always @(negedge clock) begin
        if (!reset && RVALID && RREADY) begin
            b_id.push_back(RID);
            b_data.push_back(RDATA);
            b_resp.push_back(RRESP);
            b_last.push_back(RLAST);
            b_cyc.push_back(cyc);
        end
        if (!reset && ARVALID && ARREADY) ar_cyc.push_back(cyc + 1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_all();
        b_id.delete(); b_data.delete(); b_resp.delete(); b_last.delete(); b_cyc.delete();
        ar_cyc.delete();
        e_id.delete(); e_data.delete(); e_resp.delete(); e_last.delete();
    endtask

    task automatic expect_beat(input logic [7:0] id, input logic [31:0] data,
                               input logic [1:0] resp, input logic last);
        e_id.push_back(id); e_data.push_back(data); e_resp.push_back(resp); e_last.push_back(last);
    endtask

    task automatic drive_ar(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst);
        @(posedge clock); #1;
        ARID = id; ARADDR = addr; ARLEN = len; ARSIZE = size; ARBURST = burst; ARVALID = 1'b1;
    endtask

    task automatic wait_accept(input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 64 && !ok; i++) begin
            @(negedge clock);
            if (ARREADY) ok = 1'b1;
        end
        @(posedge clock); #1;
        ARVALID = 1'b0;
        check({tag, "_ar_accept"}, 64'(ok), 64'd1);
    endtask

    task automatic wait_and_score(input string tag);
        for (int i = 0; i < 200 && b_data.size() < e_data.size(); i++) @(posedge clock);
        repeat (4) @(posedge clock);
        check({tag, "_count"}, 64'(b_data.size()), 64'(e_data.size()));
        for (int i = 0; i < e_data.size() && i < b_data.size(); i++) begin
            check($sformatf("%s_id%0d", tag, i),   64'(b_id[i]),   64'(e_id[i]));
            check($sformatf("%s_data%0d", tag, i), 64'(b_data[i]), 64'(e_data[i]));
            check($sformatf("%s_resp%0d", tag, i), 64'(b_resp[i]), 64'(e_resp[i]));
            check($sformatf("%s_last%0d", tag, i), 64'(b_last[i]), 64'(e_last[i]));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; ARVALID = 1'b0; ARID = '0; ARADDR = '0; ARLEN = '0; ARSIZE = '0; ARBURST = '0;
        RREADY = 1'b1; mem_we = 1'b0; mem_waddr = '0; mem_wdata = '0;

        for (int i = 0; i < 1024; i++) begin
            @(posedge clock); #1;
            mem_we = 1'b1; mem_waddr = 10'(i); mem_wdata = 32'(i);
        end
        @(posedge clock); #1;
        mem_we = 1'b0;
        @(posedge clock); #1;
        check("rst_arready", 64'(ARREADY), 64'd0);
        check("rst_rvalid",  64'(RVALID),  64'd0);
        check("rst_rlast",   64'(RLAST),   64'd0);
        check("rst_rresp",   64'(RRESP),   64'd0);
        check("rst_rid",     64'(RID),     64'd0);
        check("rst_rdata",   64'(RDATA),   64'd0);
        reset = 1'b0;
        repeat (2) @(posedge clock);

        // 1: INCR, gapless, latency
        clear_all();
        for (int i = 0; i < 4; i++) expect_beat(8'd5, 32'(4 + i), 2'd0, i == 3);
        drive_ar(8'd5, 32'h10, 8'd3, 3'd2, 2'd1);
        wait_accept("t1");
        wait_and_score("t1");
        if (b_cyc.size() >= 4 && ar_cyc.size() >= 1) begin
            check("t1_latency", 64'(b_cyc[0] - ar_cyc[0]), 64'd2);
            for (int i = 1; i < 4; i++)
                check($sformatf("t1_gap%0d", i), 64'(b_cyc[i] - b_cyc[i-1]), 64'd1);
        end

        // 2: WRAP
        clear_all();
`ifdef AXI4_RD_SLAVE_WRAP_EN
        expect_beat(8'd7, 32'd14, 2'd0, 1'b0);
        expect_beat(8'd7, 32'd15, 2'd0, 1'b0);
        expect_beat(8'd7, 32'd12, 2'd0, 1'b0);
        expect_beat(8'd7, 32'd13, 2'd0, 1'b1);
`else
        for (int i = 0; i < 4; i++) expect_beat(8'd7, 32'd0, 2'd2, i == 3);
`endif
        drive_ar(8'd7, 32'h38, 8'd3, 3'd2, 2'd2);
        wait_accept("t2");
        wait_and_score("t2");

        // WRAP with illegal length is SLVERR in either build
        clear_all();
        for (int i = 0; i < 3; i++) expect_beat(8'd8, 32'd0, 2'd2, i == 2);
        drive_ar(8'd8, 32'h0, 8'd2, 3'd2, 2'd2);
        wait_accept("t2b");
        wait_and_score("t2b");

        // 3: FIXED, bad size, reserved burst
        clear_all();
        for (int i = 0; i < 3; i++) expect_beat(8'd3, 32'd8, 2'd0, i == 2);
        drive_ar(8'd3, 32'h20, 8'd2, 3'd2, 2'd0);
        wait_accept("t3a");
        wait_and_score("t3a");

        clear_all();
        for (int i = 0; i < 2; i++) expect_beat(8'd4, 32'd0, 2'd2, i == 1);
        drive_ar(8'd4, 32'h20, 8'd1, 3'd1, 2'd1);
        wait_accept("t3b");
        wait_and_score("t3b");

        clear_all();
        for (int i = 0; i < 2; i++) expect_beat(8'd6, 32'd0, 2'd2, i == 1);
        drive_ar(8'd6, 32'h20, 8'd1, 3'd2, 2'd3);
        wait_accept("t3c");
        wait_and_score("t3c");

        // 4: backpressure fills queue + engine, then drains in order
        clear_all();
        @(posedge clock); #1;
        RREADY = 1'b0;
        for (int i = 1; i <= 6; i++) expect_beat(8'(i), 32'(i), 2'd0, 1'b1);
        for (int i = 1; i <= 5; i++) begin
            drive_ar(8'(i), 32'(i * 4), 8'd0, 3'd2, 2'd1);
            wait_accept($sformatf("t4_ar%0d", i));
        end
        drive_ar(8'd6, 32'd24, 8'd0, 3'd2, 2'd1);
        repeat (5) @(negedge clock);
        check("t4_arready_full", 64'(ARREADY), 64'd0);
        check("t4_accepted", 64'(ar_cyc.size()), 64'd5);
        @(posedge clock); #1;
        RREADY = 1'b1;
        wait_accept("t4_ar6");
        wait_and_score("t4");

        // 5: running off the end of memory
        clear_all();
        expect_beat(8'd9, 32'd1023, 2'd0, 1'b0);
        expect_beat(8'd9, 32'd0,    2'd3, 1'b1);
        drive_ar(8'd9, 32'hFFC, 8'd1, 3'd2, 2'd1);
        wait_accept("t5");
        wait_and_score("t5");

        // 6: reset mid-burst drops everything, memory survives
        clear_all();
        @(posedge clock); #1;
        RREADY = 1'b0;
        drive_ar(8'd11, 32'h0, 8'd7, 3'd2, 2'd1);
        wait_accept("t6_pre");
        for (int i = 0; i < 20 && !RVALID; i++) @(negedge clock);
        check("t6_rvalid_pre", 64'(RVALID), 64'd1);
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        check("t6_rvalid_rst",  64'(RVALID),  64'd0);
        check("t6_arready_rst", 64'(ARREADY), 64'd0);
        check("t6_rlast_rst",   64'(RLAST),   64'd0);
        check("t6_rdata_rst",   64'(RDATA),   64'd0);
        reset = 1'b0;
        RREADY = 1'b1;
        repeat (3) @(posedge clock);
        clear_all();
        expect_beat(8'd3, 32'd16, 2'd0, 1'b1);
        drive_ar(8'd3, 32'h40, 8'd0, 3'd2, 2'd1);
        wait_accept("t6_post");
        wait_and_score("t6_post");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
